zombie_damage_unit: RTL and testbench
=====================================

ZOMBIE_DAMAGE_UNIT -- requirements
Module: zombie_damage_unit

Interface
REQ-001 Parameter ZOM_MAX_HP, default 5: zombie HP loaded at spawn; 1..7.
REQ-002 Parameter HIT_HALF_W, default 12: horizontal hit half-extent, pixels.
REQ-003 Parameter HIT_HALF_H, default 16: vertical hit half-extent, pixels.
REQ-004 Parameter COOLDOWN_FRAMES, default 8: invulnerable frames after a hit; 1..15.
REQ-005 Parameter DYING_FRAMES, default 16: death-animation frames; 1..31.
REQ-006 frame_clk  in  1  the only clock; one cycle per video frame.
REQ-007 Reset  in  1  asynchronous, active-low reset.
REQ-008 ZomSpawn  in  1  one-cycle request to spawn a zombie; honoured only in DEAD.
REQ-009 PeaValid  in  1  pea in flight; Pea1X/Pea1Y meaningful when high.
REQ-010 Pea1X, Pea1Y  in  10 each  pea centre, pixels.
REQ-011 ZomCentralX, ZomCentralY  in  10 each  zombie centre, pixels.
REQ-012 ZomLive  out  1  zombie alive (ALIVE or COOLDOWN).
REQ-013 ZomHP  out  3  remaining zombie HP.
REQ-014 PeaHit  out  1  one-cycle pulse; pea producer retires the pea.
REQ-015 ZomFlash  out  1  high during COOLDOWN and DYING (sprite blink enable).
REQ-016 Score  out  8  zombies killed since reset, saturating.

Function
REQ-017 States: DEAD, ALIVE, COOLDOWN, DYING; registered state, single FSM.
REQ-018 Overlap = PeaValid and |Pea1X-ZomCentralX| <= HIT_HALF_W and |Pea1Y-ZomCentralY| <= HIT_HALF_H; differences computed 11-bit signed, no 10-bit wrap.
REQ-019 DEAD: ZomSpawn high -> ALIVE next edge, ZomHP <= ZOM_MAX_HP.
REQ-020 ALIVE: Overlap -> PeaHit high next cycle, ZomHP decrements by 1 same edge.
REQ-021 ALIVE hit with ZomHP=1 -> ZomHP=0, state DYING, Score +1 (hold at 255).
REQ-022 ALIVE hit with ZomHP>1 -> COOLDOWN, counter loaded COOLDOWN_FRAMES.
REQ-023 COOLDOWN: counter decrements each cycle; Overlap ignored, no PeaHit; at counter 1 -> ALIVE.
REQ-024 DYING: counter loaded DYING_FRAMES on entry; decrements; at 1 -> DEAD.
REQ-025 ZomSpawn outside DEAD ignored, no effect on HP or state.
REQ-026 ZomSpawn and a hit never coincide (DEAD has no overlap check); PeaHit never asserted outside ALIVE.
REQ-027 PeaHit at most one cycle per hit; never two consecutive cycles.
REQ-028 ZomHP holds 0 in DEAD and DYING; never underflows.
REQ-029 All outputs registered; latency Overlap-to-PeaHit exactly 1 cycle.

Reset
REQ-030 Reset low asynchronously forces DEAD, ZomHP=0, ZomLive=0, PeaHit=0, ZomFlash=0, Score=0, counter=0.
REQ-031 Reset mid-COOLDOWN/DYING aborts; first edge after release samples ZomSpawn normally.

Structure
REQ-032 Shared package game_pkg holds the zombie state enum, ZOM_MAX_HP, hit extents and frame counts defaults.
REQ-033 One sub-module natural: hit_box_cmp (combinational overlap test, reusable for plant/zombie contact).

Verification
REQ-034 Reset low 2 cycles then high -> ZomLive=0, ZomHP=0, Score=0, PeaHit=0.
REQ-035 ZomSpawn pulse in DEAD -> next cycle ZomLive=1, ZomHP=5.
REQ-036 Zombie (300,200), pea (310,210) valid -> PeaHit 1 cycle, ZomHP=4, 8 cycles COOLDOWN with no further hit, then ALIVE.
REQ-037 Pea (313,200) vs zombie (300,200) -> no hit; pea (5,200) vs zombie (1000,200) -> no hit (no wrap).
REQ-038 Five spaced hits -> ZomHP 0, Score=1, ZomFlash high 16 cycles, then DEAD, ZomLive=0.
REQ-039 Reset asserted during DYING -> immediate DEAD, Score=0; ZomSpawn during ALIVE -> ignored.

Source files
------------

// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game sprite logic: zombie life-cycle states,
// default hit extents, HP and frame-count defaults, and a helper that returns
// the absolute distance between two screen coordinates without wrap-around.
// ---------------------------------------------------------------------------
package game_pkg;

   localparam int COORD_W = 10;                // screen coordinate width, pixels

   localparam int DEF_ZOM_MAX_HP      = 5;
   localparam int DEF_HIT_HALF_W      = 12;
   localparam int DEF_HIT_HALF_H      = 16;
   localparam int DEF_COOLDOWN_FRAMES = 8;
   localparam int DEF_DYING_FRAMES    = 16;

   typedef enum logic [1:0] {
      ZS_DEAD     = 2'd0,
      ZS_ALIVE    = 2'd1,
      ZS_COOLDOWN = 2'd2,
      ZS_DYING    = 2'd3
   } zom_state_t;

   // |a - b| computed one bit wider than the coordinates, so 5 vs 1000
   // yields 995 instead of a small wrapped value.
   function automatic logic [COORD_W:0] abs_diff(input logic [COORD_W-1:0] a,
                                                 input logic [COORD_W-1:0] b);
      logic signed [COORD_W:0] d;
      logic        [COORD_W:0] r;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      if (d[COORD_W]) begin
         r = -d;
      end else begin
         r = d;
      end
      return r;
   endfunction

endpackage

// File: rtl/hit_box_cmp.sv
// ---------------------------------------------------------------------------
// hit_box_cmp
// Combinational axis-aligned box overlap test between a point (a) and a box
// centred on (b) with half-extents HALF_W x HALF_H. Edges are inclusive.
// Ports:
//   valid          in  1   point is meaningful; overlap forced low otherwise
//   ax, ay         in  10  point coordinates, pixels
//   bx, by         in  10  box centre, pixels
//   overlap        out 1   point lies within the box
// ---------------------------------------------------------------------------
module hit_box_cmp
   import game_pkg::*;
#(
   parameter int HALF_W = DEF_HIT_HALF_W,
   parameter int HALF_H = DEF_HIT_HALF_H
) (
   input  logic               valid,
   input  logic [COORD_W-1:0] ax,
   input  logic [COORD_W-1:0] ay,
   input  logic [COORD_W-1:0] bx,
   input  logic [COORD_W-1:0] by,
   output logic               overlap
);

   localparam logic [COORD_W:0] HALF_W_V = (COORD_W+1)'(HALF_W);
   localparam logic [COORD_W:0] HALF_H_V = (COORD_W+1)'(HALF_H);

   logic [COORD_W:0] dx_s;
   logic [COORD_W:0] dy_s;

   // Distance on each axis, then inclusive compare against the half-extents.
   always_comb begin
      dx_s    = abs_diff(ax, bx);
      dy_s    = abs_diff(ay, by);
      overlap = valid && (dx_s <= HALF_W_V) && (dy_s <= HALF_H_V);
   end

endmodule

// File: rtl/zombie_damage_unit.sv
// ---------------------------------------------------------------------------
// zombie_damage_unit
// Zombie life cycle and pea damage. One clock per video frame.
// DEAD -> (spawn) -> ALIVE -> (hit) -> COOLDOWN -> ALIVE ... last hit -> DYING
// -> DEAD. All outputs are registered; a hit seen on one edge shows PeaHit on
// the following cycle.
// Ports:
//   frame_clk                  in  1   frame clock
//   Reset                      in  1   async active-low reset
//   ZomSpawn                   in  1   spawn request, honoured only in DEAD
//   PeaValid                   in  1   pea in flight
//   Pea1X, Pea1Y               in  10  pea centre
//   ZomCentralX, ZomCentralY   in  10  zombie centre
//   ZomLive                    out 1   ALIVE or COOLDOWN
//   ZomHP                      out 3   remaining HP
//   PeaHit                     out 1   one-cycle hit pulse
//   ZomFlash                   out 1   COOLDOWN or DYING
//   Score                      out 8   kills since reset, saturating
// ---------------------------------------------------------------------------
module zombie_damage_unit
   import game_pkg::*;
#(
   parameter int ZOM_MAX_HP      = DEF_ZOM_MAX_HP,
   parameter int HIT_HALF_W      = DEF_HIT_HALF_W,
   parameter int HIT_HALF_H      = DEF_HIT_HALF_H,
   parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
   parameter int DYING_FRAMES    = DEF_DYING_FRAMES
) (
   input  logic                frame_clk,
   input  logic                Reset,
   input  logic                ZomSpawn,
   input  logic                PeaValid,
   input  logic [COORD_W-1:0]  Pea1X,
   input  logic [COORD_W-1:0]  Pea1Y,
   input  logic [COORD_W-1:0]  ZomCentralX,
   input  logic [COORD_W-1:0]  ZomCentralY,
   output logic                ZomLive,
   output logic [2:0]          ZomHP,
   output logic                PeaHit,
   output logic                ZomFlash,
   output logic [7:0]          Score
);

   localparam logic [2:0] HP_INIT    = 3'(ZOM_MAX_HP);
   localparam logic [4:0] CD_INIT    = 5'(COOLDOWN_FRAMES);
   localparam logic [4:0] DYING_INIT = 5'(DYING_FRAMES);

   zom_state_t  state_r, state_s;
   logic [2:0]  hp_r, hp_s;
   logic [4:0]  cnt_r, cnt_s;
   logic [7:0]  score_r, score_s;
   logic        hit_r, hit_s;
   logic        live_r, live_s;
   logic        flash_r, flash_s;
   logic        overlap_s;

   hit_box_cmp #(
      .HALF_W (HIT_HALF_W),
      .HALF_H (HIT_HALF_H)
   ) u_hit_box (
      .valid   (PeaValid),
      .ax      (Pea1X),
      .ay      (Pea1Y),
      .bx      (ZomCentralX),
      .by      (ZomCentralY),
      .overlap (overlap_s)
   );

   // Next-state, HP, frame counter, score and registered-output values.
   always_comb begin
      state_s = state_r;
      hp_s    = hp_r;
      cnt_s   = cnt_r;
      score_s = score_r;
      hit_s   = 1'b0;
      case (state_r)
         ZS_DEAD: begin
            cnt_s = 5'd0;
            if (ZomSpawn) begin
               state_s = ZS_ALIVE;
               hp_s    = HP_INIT;
            end else begin
               state_s = ZS_DEAD;
               hp_s    = 3'd0;
            end
         end
         ZS_ALIVE: begin
            if (overlap_s) begin
               hit_s = 1'b1;
               // hp <= 1 also covers a corrupted 0 so HP can never wrap.
               if (hp_r <= 3'd1) begin
                  state_s = ZS_DYING;
                  hp_s    = 3'd0;
                  cnt_s   = DYING_INIT;
                  score_s = (score_r == 8'd255) ? score_r : (score_r + 8'd1);
               end else begin
                  state_s = ZS_COOLDOWN;
                  hp_s    = hp_r - 3'd1;
                  cnt_s   = CD_INIT;
               end
            end else begin
               state_s = ZS_ALIVE;
            end
         end
         ZS_COOLDOWN: begin
            if (cnt_r <= 5'd1) begin
               state_s = ZS_ALIVE;
               cnt_s   = 5'd0;
            end else begin
               cnt_s   = cnt_r - 5'd1;
            end
         end
         ZS_DYING: begin
            hp_s = 3'd0;
            if (cnt_r <= 5'd1) begin
               state_s = ZS_DEAD;
               cnt_s   = 5'd0;
            end else begin
               cnt_s   = cnt_r - 5'd1;
            end
         end
         default: begin
            state_s = ZS_DEAD;
            hp_s    = 3'd0;
            cnt_s   = 5'd0;
         end
      endcase
      live_s  = (state_s == ZS_ALIVE) || (state_s == ZS_COOLDOWN);
      flash_s = (state_s == ZS_COOLDOWN) || (state_s == ZS_DYING);
   end

   // State and output registers.
   always_ff @(posedge frame_clk or negedge Reset) begin
      if (!Reset) begin
         state_r <= ZS_DEAD;
         hp_r    <= 3'd0;
         cnt_r   <= 5'd0;
         score_r <= 8'd0;
         hit_r   <= 1'b0;
         live_r  <= 1'b0;
         flash_r <= 1'b0;
      end else begin
         state_r <= state_s;
         hp_r    <= hp_s;
         cnt_r   <= cnt_s;
         score_r <= score_s;
         hit_r   <= hit_s;
         live_r  <= live_s;
         flash_r <= flash_s;
      end
   end

   assign ZomLive  = live_r;
   assign ZomHP    = hp_r;
   assign PeaHit   = hit_r;
   assign ZomFlash = flash_r;
   assign Score    = score_r;

endmodule

// File: tb/tb_zombie_damage_unit.sv
// ---------------------------------------------------------------------------
// tb_zombie_damage_unit
// Directed bench: a table of overlap vectors plus hand-written sequences for
// cooldown timing, death animation, reset during DYING and score saturation.
// ---------------------------------------------------------------------------
module tb_zombie_damage_unit;

   logic       frame_clk = 1'b0;
   logic       Reset;
   logic       ZomSpawn;
   logic       PeaValid;
   logic [9:0] Pea1X, Pea1Y, ZomCentralX, ZomCentralY;
   logic       ZomLive;
   logic [2:0] ZomHP;
   logic       PeaHit;
   logic       ZomFlash;
   logic [7:0] Score;

   int checks = 0;
   int errors = 0;

   zombie_damage_unit dut (
      .frame_clk   (frame_clk),
      .Reset       (Reset),
      .ZomSpawn    (ZomSpawn),
      .PeaValid    (PeaValid),
      .Pea1X       (Pea1X),
      .Pea1Y       (Pea1Y),
      .ZomCentralX (ZomCentralX),
      .ZomCentralY (ZomCentralY),
      .ZomLive     (ZomLive),
      .ZomHP       (ZomHP),
      .PeaHit      (PeaHit),
      .ZomFlash    (ZomFlash),
      .Score       (Score)
   );

   always #5 frame_clk = ~frame_clk;

   typedef struct {
      logic [9:0] px, py, zx, zy;
      logic       pv;
      logic       hit;
   } vec_t;

   vec_t vecs[11];

   task automatic step();
      @(posedge frame_clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      Reset    = 1'b0;
      ZomSpawn = 1'b0;
      PeaValid = 1'b0;
      step();
      step();
      Reset = 1'b1;
   endtask

   task automatic spawn();
      ZomSpawn = 1'b1;
      step();
      ZomSpawn = 1'b0;
   endtask

   task automatic hit_once();
      Pea1X = 10'd310; Pea1Y = 10'd210;
      ZomCentralX = 10'd300; ZomCentralY = 10'd200;
      PeaValid = 1'b1;
      step();
      PeaValid = 1'b0;
   endtask

   task automatic kill();
      spawn();
      repeat (4) begin
         hit_once();
         repeat (8) step();
      end
      hit_once();
      repeat (16) step();
   endtask

   initial begin
      int flash_cnt, live_cnt, hit_cnt;
      Pea1X = 10'd0; Pea1Y = 10'd0; ZomCentralX = 10'd300; ZomCentralY = 10'd200;
      PeaValid = 1'b0; ZomSpawn = 1'b0; Reset = 1'b1;

      //            px      py      zx       zy      pv    hit
      vecs[0]  = '{10'd310, 10'd210, 10'd300,  10'd200, 1'b1, 1'b1};
      vecs[1]  = '{10'd313, 10'd200, 10'd300,  10'd200, 1'b1, 1'b0};
      vecs[2]  = '{10'd312, 10'd200, 10'd300,  10'd200, 1'b1, 1'b1};
      vecs[3]  = '{10'd288, 10'd216, 10'd300,  10'd200, 1'b1, 1'b1};
      vecs[4]  = '{10'd300, 10'd217, 10'd300,  10'd200, 1'b1, 1'b0};
      vecs[5]  = '{10'd300, 10'd183, 10'd300,  10'd200, 1'b1, 1'b0};
      vecs[6]  = '{10'd5,   10'd200, 10'd1000, 10'd200, 1'b1, 1'b0};
      vecs[7]  = '{10'd1020,10'd200, 10'd2,    10'd200, 1'b1, 1'b0};
      vecs[8]  = '{10'd300, 10'd200, 10'd300,  10'd200, 1'b0, 1'b0};
      vecs[9]  = '{10'd300, 10'd200, 10'd300,  10'd200, 1'b1, 1'b1};
      vecs[10] = '{10'd0,   10'd0,   10'd0,    10'd0,   1'b1, 1'b1};

      // Reset state
      do_reset();
      chk("rst_live",  ZomLive,  0);
      chk("rst_hp",    ZomHP,    0);
      chk("rst_score", Score,    0);
      chk("rst_hit",   PeaHit,   0);
      chk("rst_flash", ZomFlash, 0);

      // Overlap table: fresh zombie, one pea frame, check pulse and HP
      for (int i = 0; i < 11; i++) begin
         do_reset();
         spawn();
         Pea1X = vecs[i].px; Pea1Y = vecs[i].py;
         ZomCentralX = vecs[i].zx; ZomCentralY = vecs[i].zy;
         PeaValid = vecs[i].pv;
         step();
         PeaValid = 1'b0;
         chk($sformatf("vec%0d_hit", i), PeaHit, vecs[i].hit);
         chk($sformatf("vec%0d_hp", i), ZomHP, vecs[i].hit ? 4 : 5);
      end

      // Spawn, then a held pea: one hit, 8 cooldown frames, then next hit
      do_reset();
      spawn();
      chk("spawn_live",  ZomLive,  1);
      chk("spawn_hp",    ZomHP,    5);
      chk("spawn_flash", ZomFlash, 0);
      Pea1X = 10'd310; Pea1Y = 10'd210; ZomCentralX = 10'd300; ZomCentralY = 10'd200;
      PeaValid = 1'b1;
      step();
      chk("cd_hit",   PeaHit,   1);
      chk("cd_hp",    ZomHP,    4);
      chk("cd_flash", ZomFlash, 1);
      flash_cnt = 0; hit_cnt = 0;
      for (int i = 0; i < 7; i++) begin
         step();
         flash_cnt += int'(ZomFlash);
         hit_cnt   += int'(PeaHit);
      end
      chk("cd_flash_frames", flash_cnt, 7);
      chk("cd_no_hits",      hit_cnt,   0);
      step();
      chk("cd_end_flash", ZomFlash, 0);
      chk("cd_end_live",  ZomLive,  1);
      chk("cd_end_hit",   PeaHit,   0);
      step();
      chk("rehit_hit", PeaHit, 1);
      chk("rehit_hp",  ZomHP,  3);
      step();
      chk("no_consec_hit", PeaHit, 0);
      PeaValid = 1'b0;
      repeat (7) step();

      // Spawn while ALIVE is ignored
      spawn();
      chk("alive_spawn_hp",   ZomHP,   3);
      chk("alive_spawn_live", ZomLive, 1);

      // Finish off the zombie and watch the death animation
      hit_once();
      repeat (8) step();
      hit_once();
      repeat (8) step();
      hit_once();
      chk("kill_hit",   PeaHit,   1);
      chk("kill_hp",    ZomHP,    0);
      chk("kill_score", Score,    1);
      chk("kill_flash", ZomFlash, 1);
      chk("kill_live",  ZomLive,  0);
      flash_cnt = 0; live_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         ZomSpawn = (i == 5);
         step();
         flash_cnt += int'(ZomFlash);
         live_cnt  += int'(ZomLive);
      end
      ZomSpawn = 1'b0;
      chk("dying_flash_frames", flash_cnt, 15);
      chk("dying_live_frames",  live_cnt,  0);
      step();
      chk("dead_flash", ZomFlash, 0);
      chk("dead_live",  ZomLive,  0);
      chk("dead_hp",    ZomHP,    0);
      chk("dead_score", Score,    1);

      // Reset in the middle of DYING aborts at once
      spawn();
      repeat (4) begin
         hit_once();
         repeat (8) step();
      end
      hit_once();
      repeat (3) step();
      Reset = 1'b0;
      #1;
      chk("arst_live",  ZomLive,  0);
      chk("arst_flash", ZomFlash, 0);
      chk("arst_score", Score,    0);
      chk("arst_hp",    ZomHP,    0);
      #2;
      Reset = 1'b1;
      spawn();
      chk("post_rst_live", ZomLive, 1);
      chk("post_rst_hp",   ZomHP,   5);

      // Score saturates at 255
      do_reset();
      repeat (255) kill();
      chk("score_255", Score, 255);
      kill();
      chk("score_sat", Score, 255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
